// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream loaded instruction store that releases the processor once full
module program_loader #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instruction,
    output logic              cpu_run,
    output logic              load_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        byte_cnt;
    logic [23:0]       asm_word;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              load_done_q;

    logic accept;
    logic word_done;
    logic last_word;

    // A restart in the same cycle as a valid byte wins; that byte is dropped.
    assign accept    = (state == LOAD) && byte_valid && !load_start;
    assign word_done = accept && (byte_cnt == 2'd3);
    assign last_word = word_done && (&wr_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (load_start) state_nxt = LOAD;
            LOAD: if (last_word)  state_nxt = RUN;
            RUN:  if (load_start) state_nxt = LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr     <= '0;
            byte_cnt    <= '0;
            asm_word    <= '0;
            load_done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            load_done_q <= last_word;
            if (load_start) begin
                wr_addr  <= '0;
                byte_cnt <= '0;
            end else if (accept) begin
                if (word_done) begin
                    mem[wr_addr] <= {byte_in, asm_word};
                    wr_addr      <= wr_addr + ADDR_W'(1);
                    byte_cnt     <= '0;
                end else begin
                    asm_word[{byte_cnt, 3'b000} +: 8] <= byte_in;
                    byte_cnt                          <= byte_cnt + 2'd1;
                end
            end
        end
    end

    // A halted processor fetches zero (NOP) whatever address it drives.
    assign byte_ready  = (state == LOAD);
    assign cpu_run     = (state == RUN);
    assign instruction = cpu_run ? mem[address] : '0;
    assign load_done   = load_done_q;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

    localparam int ADDR_W = 3;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = 4 * DEPTH;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_start = 1'b0;
    logic [7:0]        byte_in = 8'h00;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic [ADDR_W-1:0] address = '0;
    logic [31:0]       instruction;
    logic              cpu_run;
    logic              load_done;

    program_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_start  (load_start),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .address     (address),
        .instruction (instruction),
        .cpu_run     (cpu_run),
        .load_done   (load_done)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_mem [DEPTH];
    bit          model_run = 1'b0;
    int          done_pulses = 0;
    int          exp_pulses = 0;
    logic [7:0]  stream_q [$];

    always @(negedge clk) begin
        if (load_done === 1'b1) done_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; sweeps every address within the same cycle.
    task automatic check_reads(input string tag);
        for (int a = 0; a < DEPTH; a++) begin
            address = ADDR_W'(a);
            #1;
            check(tag, instruction, model_run ? model_mem[a] : 32'h0);
        end
    endtask

    task automatic pulse_start(input bit with_byte, input logic [7:0] b);
        load_start = 1'b1;
        byte_valid = with_byte;
        byte_in    = b;
        @(posedge clk); #1;
        load_start = 1'b0;
        byte_valid = 1'b0;
        model_run  = 1'b0;
        check("start_ready", byte_ready, 1);
        check("start_run", cpu_run, 0);
        check("start_done", load_done, 0);
    endtask

    task automatic fill_const(input int n, input logic [7:0] v);
        stream_q.delete();
        for (int i = 0; i < n; i++) stream_q.push_back(v);
    endtask

    task automatic fill_rand(input int n);
        stream_q.delete();
        for (int i = 0; i < n; i++) stream_q.push_back(8'($urandom));
    endtask

    task automatic fill_ramp();
        stream_q.delete();
        for (int i = 0; i < NBYTES; i++) stream_q.push_back(8'(i));
    endtask

    // Streams stream_q from a fresh load; gap_pct is the chance of an idle cycle.
    task automatic stream(input int gap_pct, input bit completes);
        int idx = 0;
        int cycles = 0;
        bit acc;
        while (idx < stream_q.size() && cycles < 4000) begin
            acc        = ($urandom_range(99) >= gap_pct);
            byte_valid = acc;
            byte_in    = acc ? stream_q[idx] : 8'($urandom);
            check("load_ready", byte_ready, 1);
            @(posedge clk); #1;
            cycles++;
            if (acc) idx++;
            if (acc && completes && idx == stream_q.size()) begin
                check("final_done", load_done, 1);
                check("final_run", cpu_run, 1);
                check("final_ready", byte_ready, 0);
                exp_pulses++;
            end else begin
                check("early_done", load_done, 0);
            end
        end
        byte_valid = 1'b0;
        check("stream_len", idx, stream_q.size());
        for (int w = 0; w < idx / 4; w++) begin
            model_mem[w] = {stream_q[4*w+3], stream_q[4*w+2], stream_q[4*w+1], stream_q[4*w]};
        end
        if (completes && idx == stream_q.size()) begin
            model_run = 1'b1;
            @(posedge clk); #1;
            check("done_width", load_done, 0);
            check("run_hold", cpu_run, 1);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        model_run = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("rst_run", cpu_run, 0);
        check("rst_ready", byte_ready, 0);
        check("rst_done", load_done, 0);
        check_reads("rst_instr");

        // Bytes in IDLE are ignored.
        byte_valid = 1'b1;
        byte_in    = 8'h77;
        repeat (3) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        check("idle_ready", byte_ready, 0);
        check("idle_run", cpu_run, 0);

        // Full back-to-back load.
        fill_ramp();
        pulse_start(1'b0, 8'h00);
        stream(0, 1'b1);
        check_reads("full_read");
        address = 0; #1;
        check("full_addr0", instruction, 32'h03020100);
        address = 7; #1;
        check("full_addr7", instruction, 32'h1F1E1D1C);
        @(posedge clk); #1;

        // Throttled load of the same data.
        pulse_start(1'b0, 8'h00);
        check_reads("load_instr");
        stream(50, 1'b1);
        check_reads("thr_read");

        // Partial load, restart with a colliding byte, then all 0x55.
        pulse_start(1'b0, 8'h00);
        fill_rand(13);
        stream(20, 1'b0);
        pulse_start(1'b1, 8'hAA);
        fill_const(NBYTES, 8'h55);
        stream(30, 1'b1);
        check_reads("restart_read");
        address = 3; #1;
        check("restart_word", instruction, 32'h55555555);
        @(posedge clk); #1;

        // Reload from RUN with 0xFF.
        pulse_start(1'b0, 8'h00);
        check_reads("reload_instr");
        fill_const(NBYTES, 8'hFF);
        stream(0, 1'b1);
        check_reads("ff_read");
        address = 5; #1;
        check("ff_word", instruction, 32'hFFFFFFFF);
        @(posedge clk); #1;

        // Random contents with random gaps.
        for (int r = 0; r < 3; r++) begin
            pulse_start(1'b0, 8'h00);
            fill_rand(NBYTES);
            stream($urandom_range(60), 1'b1);
            check_reads("rand_read");
        end

        // Async reset mid-load.
        pulse_start(1'b0, 8'h00);
        fill_rand(20);
        stream(10, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("arst_load_ready", byte_ready, 0);
        check("arst_load_run", cpu_run, 0);
        model_clear();
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_idle_ready", byte_ready, 0);

        // Async reset while running clears outputs without a clock edge.
        fill_rand(NBYTES);
        pulse_start(1'b0, 8'h00);
        stream(20, 1'b1);
        address = 2;
        #3 rst_n = 1'b0;
        #1;
        check("arst_run_run", cpu_run, 0);
        check("arst_run_instr", instruction, 0);
        check("arst_run_done", load_done, 0);
        model_clear();
        #2 rst_n = 1'b1;
        byte_valid = 1'b1;
        byte_in    = 8'h3C;
        repeat (4) @(posedge clk);
        #1;
        byte_valid = 1'b0;
        check("arst_after_ready", byte_ready, 0);
        check("arst_after_run", cpu_run, 0);
        check_reads("arst_after_instr");

        fill_rand(NBYTES);
        pulse_start(1'b0, 8'h00);
        stream(25, 1'b1);
        check_reads("final_read");

        check("done_pulses", done_pulses, exp_pulses);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
